// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, 3-sample mid-bit majority vote,
// optional parity, 1 or 2 stop bits, and a small output FIFO with valid/ready.
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_parity_err,
  output logic                 m_frame_err,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
  localparam int HALF       = BIT_PERIOD / 2;
  localparam int CNT_W      = $clog2(BIT_PERIOD);
  localparam int IDX_W      = $clog2(DATA_BITS);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int EW         = DATA_BITS + 2;

  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(HALF + 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(BIT_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_ONE = (STOP_BITS == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_samp0;
  logic                 r_samp1;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_stopIdx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parErr;
  logic                 r_frameErr;
  logic                 r_overrun;
  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wptr;
  logic [AW:0]          r_rptr;

  logic                 w_rxs;
  logic                 w_maj;
  logic                 w_decide;
  logic                 w_bitEnd;
  logic                 w_stopLast;
  logic                 w_frameStart;
  logic                 w_shiftEn;
  logic                 w_parityEn;
  logic                 w_stopEn;
  logic                 w_push;
  logic                 w_parityXor;
  logic                 w_parErrNow;
  logic                 w_frameErrNow;
  logic [EW-1:0]        w_entry;
  logic [EW-1:0]        w_head;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_write;

  assign w_rxs      = r_sync2;
  assign w_maj      = (r_samp0 & r_samp1) | (r_samp0 & w_rxs) | (r_samp1 & w_rxs);
  assign w_decide   = (r_cnt == CNT_DEC);
  assign w_bitEnd   = (r_cnt == CNT_END);
  assign w_stopLast = STOP_ONE | r_stopIdx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // The last stop bit pushes and returns to IDLE at its mid-bit decision so the
  // next start edge is seen without losing half a bit.
  always_comb begin
    w_stateNext  = r_state;
    w_frameStart = 1'b0;
    w_shiftEn    = 1'b0;
    w_parityEn   = 1'b0;
    w_stopEn     = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_stateNext  = S_START;
          w_frameStart = 1'b1;
        end
      end
      S_START: begin
        if (w_decide && w_maj) begin
          w_stateNext = S_IDLE;
        end else if (w_bitEnd) begin
          w_stateNext = S_DATA;
        end
      end
      S_DATA: begin
        w_shiftEn = w_decide;
        if (w_bitEnd && (r_idx == IDX_LAST)) begin
          w_stateNext = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        w_parityEn = w_decide;
        if (w_bitEnd) begin
          w_stateNext = S_STOP;
        end
      end
      S_STOP: begin
        w_stopEn = w_decide;
        if (w_decide && w_stopLast) begin
          w_push      = 1'b1;
          w_stateNext = S_IDLE;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  assign w_parityXor   = (^r_shift) ^ w_maj;
  assign w_parErrNow   = (PARITY == 1) ? ~w_parityXor : w_parityXor;
  assign w_frameErrNow = r_frameErr | (w_stopEn & ~w_maj);
  assign w_entry       = {w_frameErrNow, r_parErr, r_shift};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_samp0    <= 1'b1;
      r_samp1    <= 1'b1;
      r_idx      <= '0;
      r_stopIdx  <= 1'b0;
      r_shift    <= '0;
      r_parErr   <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) || (w_stateNext == S_IDLE) || w_bitEnd) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_cnt == CNT_S0) begin
        r_samp0 <= w_rxs;
      end
      if (r_cnt == CNT_S1) begin
        r_samp1 <= w_rxs;
      end
      if (w_frameStart) begin
        r_idx      <= '0;
        r_stopIdx  <= 1'b0;
        r_parErr   <= 1'b0;
        r_frameErr <= 1'b0;
      end else begin
        if ((r_state == S_DATA) && w_bitEnd) begin
          r_idx <= r_idx + 1'b1;
        end
        if ((r_state == S_STOP) && w_bitEnd) begin
          r_stopIdx <= 1'b1;
        end
        if (w_parityEn) begin
          r_parErr <= w_parErrNow;
        end
        if (w_stopEn) begin
          r_frameErr <= w_frameErrNow;
        end
      end
      if (w_shiftEn) begin
        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
      end
    end
  end

  // Pointers carry an extra wrap bit so full and empty can be told apart.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && m_ready;
  assign w_write = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_write) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_overrun <= w_push && w_full && !w_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_write) begin
      r_mem[r_wptr[AW-1:0]] <= w_entry;
    end
  end

  assign w_head       = r_mem[r_rptr[AW-1:0]];
  assign m_valid      = !w_empty;
  assign m_data       = m_valid ? w_head[DATA_BITS-1:0] : '0;
  assign m_parity_err = m_valid & w_head[DATA_BITS];
  assign m_frame_err  = m_valid & w_head[DATA_BITS+1];
  assign overrun      = r_overrun;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Table-driven bench for uart_rx_cfg: three receivers (8N1, 8E1, 8N2) share one
// stimulus line; accepted words are logged and compared with hand-computed values.
module tb_uart_rx_cfg;

  localparam int BP = 10;

  typedef struct {
    int         which;
    logic [7:0] data;
    logic [2:0] tail;
    int         tailLen;
    int         glitch;
    logic [7:0] expData;
    logic       expPe;
    logic       expFe;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       rxLine;
  int         sel;
  logic       rxA, rxB, rxC;
  logic [7:0] dA, dB, dC;
  logic       peA, peB, peC;
  logic       feA, feB, feC;
  logic       vA, vB, vC;
  logic       rdyA, rdyB, rdyC;
  logic       ovA, ovB, ovC;
  logic       busyA, busyB, busyC;

  logic [11:0] capQ[$];
  int          ovCnt;
  int          totalCount;
  int          badCount;
  vec_t        vecs[11];

  assign rxA = (sel == 0) ? rxLine : 1'b1;
  assign rxB = (sel == 1) ? rxLine : 1'b1;
  assign rxC = (sel == 2) ? rxLine : 1'b1;

  uart_rx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .FIFO_DEPTH(4)) uA (
    .clk(clk), .rst(rst), .rx(rxA), .m_data(dA), .m_parity_err(peA), .m_frame_err(feA),
    .m_valid(vA), .m_ready(rdyA), .overrun(ovA), .busy(busyA));

  uart_rx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2),
                .STOP_BITS(1), .FIFO_DEPTH(4)) uB (
    .clk(clk), .rst(rst), .rx(rxB), .m_data(dB), .m_parity_err(peB), .m_frame_err(feB),
    .m_valid(vB), .m_ready(rdyB), .overrun(ovB), .busy(busyB));

  uart_rx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(2), .FIFO_DEPTH(4)) uC (
    .clk(clk), .rst(rst), .rx(rxC), .m_data(dC), .m_parity_err(peC), .m_frame_err(feC),
    .m_valid(vC), .m_ready(rdyC), .overrun(ovC), .busy(busyC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every accepted word as {which, fe, pe, data} and count overrun pulses.
  always @(negedge clk) begin
    #2;
    if (vA && rdyA) capQ.push_back({2'd0, feA, peA, dA});
    if (vB && rdyB) capQ.push_back({2'd1, feB, peB, dB});
    if (vC && rdyC) capQ.push_back({2'd2, feC, peC, dC});
    if (ovA) ovCnt = ovCnt + 1;
    if (ovB) ovCnt = ovCnt + 1;
    if (ovC) ovCnt = ovCnt + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    totalCount = totalCount + 1;
    if (act != exp) begin
      badCount = badCount + 1;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input int which, input logic [7:0] data, input logic [2:0] tail,
                                 input int tailLen, input int glitch, input logic [7:0] expData,
                                 input logic expPe, input logic expFe);
    vec_t v;
    v.which   = which;
    v.data    = data;
    v.tail    = tail;
    v.tailLen = tailLen;
    v.glitch  = glitch;
    v.expData = expData;
    v.expPe   = expPe;
    v.expFe   = expFe;
    return v;
  endfunction

  function automatic vec_t mkVecA(input logic [7:0] data);
    return mkVec(0, data, 3'b001, 1, -1, data, 1'b0, 1'b0);
  endfunction

  // Drives bit c/BP of the frame during cycle c, optionally inverting one cycle.
  task automatic driveFrame(input logic [15:0] bits, input int nbits, input int glitch,
                            input int maxCycles);
    for (int c = 0; (c < nbits * BP) && (c < maxCycles); c++) begin
      rxLine = bits[c / BP] ^ (c == glitch);
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [15:0] frame;
    sel   = v.which;
    frame = {4'hF, v.tail, v.data, 1'b0};
    driveFrame(frame, 9 + v.tailLen, v.glitch, 1000);
    rxLine = 1'b1;
    waitCycles(20);
  endtask

  task automatic runVec(input vec_t v, input string tag);
    int          qBase;
    int          ovBase;
    logic [11:0] e;
    qBase  = capQ.size();
    ovBase = ovCnt;
    applyStimulus(v);
    checkOutput({tag, " count"}, capQ.size() - qBase, 1);
    e = (capQ.size() > qBase) ? capQ[qBase] : 12'hFFF;
    checkOutput({tag, " which"}, e[11:10], v.which);
    checkOutput({tag, " data"}, e[7:0], v.expData);
    checkOutput({tag, " parity_err"}, e[8], v.expPe);
    checkOutput({tag, " frame_err"}, e[9], v.expFe);
    checkOutput({tag, " overrun"}, ovCnt - ovBase, 0);
  endtask

  initial begin
    int          qBase;
    int          ovBase;
    logic [11:0] e;
    logic [7:0]  expD;

    totalCount = 0;
    badCount   = 0;
    ovCnt      = 0;
    rst        = 1'b1;
    rxLine     = 1'b1;
    sel        = 0;
    rdyA       = 1'b1;
    rdyB       = 1'b1;
    rdyC       = 1'b1;

    vecs[0]  = mkVec(0, 8'hA5, 3'b001, 1, -1, 8'hA5, 1'b0, 1'b0);
    vecs[1]  = mkVec(1, 8'h0F, 3'b011, 2, -1, 8'h0F, 1'b1, 1'b0);
    vecs[2]  = mkVec(1, 8'h0F, 3'b010, 2, -1, 8'h0F, 1'b0, 1'b0);
    vecs[3]  = mkVec(1, 8'h80, 3'b011, 2, -1, 8'h80, 1'b0, 1'b0);
    vecs[4]  = mkVec(0, 8'h96, 3'b000, 1, -1, 8'h96, 1'b0, 1'b1);
    vecs[5]  = mkVec(2, 8'h5A, 3'b001, 2, -1, 8'h5A, 1'b0, 1'b1);
    vecs[6]  = mkVec(2, 8'h5A, 3'b011, 2, -1, 8'h5A, 1'b0, 1'b0);
    vecs[7]  = mkVec(2, 8'hC3, 3'b010, 2, -1, 8'hC3, 1'b0, 1'b1);
    vecs[8]  = mkVec(0, 8'h00, 3'b001, 1, 46, 8'h00, 1'b0, 1'b0);
    vecs[9]  = mkVec(0, 8'hFF, 3'b001, 1, 16, 8'hFF, 1'b0, 1'b0);
    vecs[10] = mkVec(1, 8'h81, 3'b011, 2, 56, 8'h81, 1'b1, 1'b0);

    waitCycles(3);
    checkOutput("reset m_valid", vA, 0);
    checkOutput("reset m_data", dA, 0);
    checkOutput("reset parity_err", peA, 0);
    checkOutput("reset frame_err", feA, 0);
    checkOutput("reset overrun", ovA, 0);
    checkOutput("reset busy", busyA, 0);
    rst = 1'b0;
    waitCycles(3);

    for (int i = 0; i < 11; i++) begin
      runVec(vecs[i], $sformatf("vec%0d", i));
    end

    // False start: a 3-cycle low pulse is rejected at the start-bit decision.
    sel   = 0;
    qBase = capQ.size();
    rxLine = 1'b0;
    waitCycles(3);
    rxLine = 1'b1;
    checkOutput("false start busy high", busyA, 1);
    waitCycles(10);
    checkOutput("false start busy low", busyA, 0);
    checkOutput("false start m_valid", vA, 0);
    checkOutput("false start no push", capQ.size() - qBase, 0);
    runVec(mkVecA(8'h3C), "after false start");

    // Overflow: four words fill the FIFO, the fifth is dropped with one overrun pulse.
    rdyA   = 1'b0;
    ovBase = ovCnt;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(mkVecA(8'(8'h11 * k)));
    end
    checkOutput("fill no overrun", ovCnt - ovBase, 0);
    checkOutput("fill m_valid", vA, 1);
    checkOutput("fill head", dA, 8'h11);
    applyStimulus(mkVecA(8'h55));
    checkOutput("overrun pulses", ovCnt - ovBase, 1);
    qBase = capQ.size();
    rdyA  = 1'b1;
    waitCycles(8);
    checkOutput("drain count", capQ.size() - qBase, 4);
    for (int k = 0; k < 4; k++) begin
      e    = (capQ.size() > qBase + k) ? capQ[qBase + k] : 12'hFFF;
      expD = 8'(8'h11 * (k + 1));
      checkOutput($sformatf("drain word%0d", k), e[7:0], expD);
    end
    checkOutput("drain empty", vA, 0);

    // Reset in the middle of a data bit with a word still held in the FIFO.
    rdyA = 1'b0;
    applyStimulus(mkVecA(8'h66));
    checkOutput("pre-reset m_valid", vA, 1);
    sel = 0;
    driveFrame({4'hF, 3'b001, 8'h77, 1'b0}, 10, -1, 45);
    checkOutput("pre-reset busy", busyA, 1);
    rst    = 1'b1;
    rxLine = 1'b1;
    waitCycles(1);
    checkOutput("mid reset m_valid", vA, 0);
    checkOutput("mid reset m_data", dA, 0);
    checkOutput("mid reset parity_err", peA, 0);
    checkOutput("mid reset frame_err", feA, 0);
    checkOutput("mid reset overrun", ovA, 0);
    checkOutput("mid reset busy", busyA, 0);
    rst  = 1'b0;
    rdyA = 1'b1;
    waitCycles(5);
    checkOutput("post reset m_valid", vA, 0);
    runVec(mkVecA(8'h5A), "after reset");

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
